// File: rtl/preamble_frame_arbiter.sv
// Round-robin frame scheduler that shares one preamble inserter between two sample sources.
// The granted source owns the stream for exactly one frame, and its frame config is latched for that frame.
module preamble_frame_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int CFG_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] s0_data,
  input  logic                  s0_valid,
  output logic                  s0_ready,
  input  logic [CFG_WIDTH-1:0]  s0_preamble_value,
  input  logic [CFG_WIDTH-1:0]  s0_frame_length,
  input  logic [DATA_WIDTH-1:0] s1_data,
  input  logic                  s1_valid,
  output logic                  s1_ready,
  input  logic [CFG_WIDTH-1:0]  s1_preamble_value,
  input  logic [CFG_WIDTH-1:0]  s1_frame_length,
  input  logic [CFG_WIDTH-1:0]  preamble_length,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CFG_WIDTH-1:0]  cfg_preamble_value,
  output logic [CFG_WIDTH-1:0]  cfg_frame_length,
  output logic [CFG_WIDTH-1:0]  cfg_preamble_length,
  output logic [1:0]            grant,
  output logic                  busy,
  output logic                  error
);

  typedef enum logic [1:0] {IDLE, LOAD, PASS} state_t;

  localparam logic [CFG_WIDTH-1:0] CFG_ONE = CFG_WIDTH'(1);

  state_t               state;
  logic                 sel;        // 0 selects source 0
  logic                 ptr;        // source that wins a tie
  logic [CFG_WIDTH-1:0] beat_cnt;

  logic                 in_pass;
  logic                 sel_valid;
  logic                 next_sel;
  logic                 hs;
  logic                 last_beat;
  logic [CFG_WIDTH-1:0] sel_frame_length;
  logic [CFG_WIDTH-1:0] sel_preamble_value;

  assign in_pass            = (state == PASS);
  assign sel_valid          = sel ? s1_valid : s0_valid;
  assign sel_frame_length   = sel ? s1_frame_length : s0_frame_length;
  assign sel_preamble_value = sel ? s1_preamble_value : s0_preamble_value;
  assign next_sel           = (s0_valid && s1_valid) ? ptr : s1_valid;

  // Zero-latency pass-through; everything is forced low outside PASS.
  assign m_valid  = in_pass && sel_valid;
  assign m_data   = in_pass ? (sel ? s1_data : s0_data) : '0;
  assign s0_ready = in_pass && !sel && m_ready;
  assign s1_ready = in_pass &&  sel && m_ready;

  assign hs        = m_valid && m_ready;
  assign last_beat = (beat_cnt == cfg_frame_length - CFG_ONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state               <= IDLE;
      sel                 <= 1'b0;
      ptr                 <= 1'b0;
      beat_cnt            <= '0;
      grant               <= 2'b00;
      busy                <= 1'b0;
      error               <= 1'b0;
      cfg_preamble_value  <= '0;
      cfg_frame_length    <= '0;
      cfg_preamble_length <= '0;
    end else begin
      error <= 1'b0;
      case (state)
        IDLE: begin
          if (s0_valid || s1_valid) begin
            sel   <= next_sel;
            grant <= next_sel ? 2'b10 : 2'b01;
            busy  <= 1'b1;
            state <= LOAD;
          end
        end
        LOAD: begin
          cfg_preamble_value  <= sel_preamble_value;
          cfg_frame_length    <= sel_frame_length;
          cfg_preamble_length <= preamble_length;
          beat_cnt            <= '0;
          // A zero-length frame is rejected and the source loses its turn.
          if (sel_frame_length == '0) begin
            error <= 1'b1;
            ptr   <= ~sel;
            grant <= 2'b00;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            state <= PASS;
          end
        end
        PASS: begin
          if (hs) begin
            if (last_beat) begin
              ptr   <= ~sel;
              grant <= 2'b00;
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              beat_cnt <= beat_cnt + CFG_ONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
